// File: rtl/sliding_window_gen_if.sv
// Pixel stream into the window generator and registered window stream out.
// slave is the generator side; master is the pixel source / window consumer.
interface sliding_window_gen_if #(
  parameter int PIX_W = 4,
  parameter int WIN   = 3,
  parameter int XW    = 10,
  parameter int YW    = 9
);
  logic [PIX_W-1:0] pixelIn;
  logic             pixelValid;
  logic             sof;
  logic [WIN-1:0][WIN-1:0][PIX_W-1:0] window;
  logic             windowValid;
  logic [XW-1:0]    centreX;
  logic [YW-1:0]    centreY;
  logic             frameDone;

  modport master (
    output pixelIn, pixelValid, sof,
    input  window, windowValid,
    input  centreX, centreY, frameDone
  );

  modport slave (
    input  pixelIn, pixelValid, sof,
    output window, windowValid,
    output centreX, centreY, frameDone
  );
endinterface

// File: rtl/sliding_window_gen.sv
// Line-buffer window generator: raster pixels in, WIN x WIN
// neighbourhoods with centre coordinates out, one cycle later.
module sliding_window_gen #(
  parameter int PIX_W = 4,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int WIN   = 3,
  localparam int XW   = $clog2(IMG_W),
  localparam int YW   = $clog2(IMG_H)
) (
  input logic                 mainClk,
  input logic                 nreset,
  sliding_window_gen_if.slave bus
);
  localparam int HALF = (WIN - 1) / 2;
  localparam int NLB  = WIN - 1;

  typedef logic [WIN-1:0][WIN-1:0][PIX_W-1:0] win_t;

  logic [PIX_W-1:0] line_mem [NLB][IMG_W];
  logic [NLB-1:0][PIX_W-1:0] col_rd;

  logic [XW-1:0] x_q, x_d, x_cur;
  logic [YW-1:0] y_q, y_d, y_cur;
  win_t sh_q, sh_d, sh_nxt;
  win_t win_q, win_d;
  logic vld_q, vld_d;
  logic done_q, done_d;
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic acc, last_x, last_y, emit;

  assign acc = bus.pixelValid;

  // sof relabels the current pixel as (0,0)
  always_comb begin
    x_cur  = bus.sof ? '0 : x_q;
    y_cur  = bus.sof ? '0 : y_q;
    last_x = (x_cur == XW'(IMG_W - 1));
    last_y = (y_cur == YW'(IMG_H - 1));
    emit   = (x_cur >= XW'(WIN - 1)) &&
             (y_cur >= YW'(WIN - 1));
  end

  always_comb begin
    for (int k = 0; k < NLB; k++) begin
      col_rd[k] = line_mem[k][x_cur];
    end
  end

  always_ff @(posedge mainClk) begin
    if (acc) begin
      line_mem[0][x_cur] <= bus.pixelIn;
      for (int k = 1; k < NLB; k++) begin
        line_mem[k][x_cur] <= col_rd[k-1];
      end
    end
  end

  // deepest line buffer feeds the top row
  always_comb begin
    sh_nxt = sh_q;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++) begin
        sh_nxt[r][c] = sh_q[r][c+1];
      end
    end
    for (int r = 0; r < WIN - 1; r++) begin
      sh_nxt[r][WIN-1] = col_rd[NLB-1-r];
    end
    sh_nxt[WIN-1][WIN-1] = bus.pixelIn;
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    sh_d   = sh_q;
    win_d  = win_q;
    cx_d   = cx_q;
    cy_d   = cy_q;
    vld_d  = 1'b0;
    done_d = 1'b0;
    if (acc) begin
      sh_d = sh_nxt;
      unique case (1'b1)
        !last_x: begin
          x_d = x_cur + XW'(1);
          y_d = y_cur;
        end
        last_x && !last_y: begin
          x_d = '0;
          y_d = y_cur + YW'(1);
        end
        last_x && last_y: begin
          x_d = '0;
          y_d = '0;
        end
      endcase
      if (emit) begin
        vld_d  = 1'b1;
        win_d  = sh_nxt;
        cx_d   = x_cur - XW'(HALF);
        cy_d   = y_cur - YW'(HALF);
        done_d = last_x && last_y;
      end
    end
  end

  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      x_q    <= '0;
      y_q    <= '0;
      sh_q   <= '0;
      win_q  <= '0;
      cx_q   <= '0;
      cy_q   <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      sh_q   <= sh_d;
      win_q  <= win_d;
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      vld_q  <= vld_d;
      done_q <= done_d;
    end
  end

  assign bus.window      = win_q;
  assign bus.windowValid = vld_q;
  assign bus.centreX     = cx_q;
  assign bus.centreY     = cy_q;
  assign bus.frameDone   = done_q;
endmodule

// File: tb/tb_sliding_window_gen.sv
// Bench for sliding_window_gen: 3x3 and 5x5 instances on an 8x6 image,
// checked against an image-array reference model.
module tb_sliding_window_gen;
  localparam int PW   = 4;
  localparam int IW   = 8;
  localparam int IH   = 6;
  localparam int NPIX = IW * IH;
  localparam int XW   = $clog2(IW);
  localparam int YW   = $clog2(IH);

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  sliding_window_gen_if #(.PIX_W(PW), .WIN(3), .XW(XW), .YW(YW)) if3 ();
  sliding_window_gen_if #(.PIX_W(PW), .WIN(5), .XW(XW), .YW(YW)) if5 ();

  sliding_window_gen #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH), .WIN(3)) u3 (
    .mainClk(clk), .nreset(nreset), .bus(if3)
  );
  sliding_window_gen #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH), .WIN(5)) u5 (
    .mainClk(clk), .nreset(nreset), .bus(if5)
  );

  logic [127:0]  obs_w  [2];
  logic          obs_v  [2];
  logic          obs_f  [2];
  logic [XW-1:0] obs_cx [2];
  logic [YW-1:0] obs_cy [2];

  always_comb begin
    obs_w[0]  = 128'(if3.window);
    obs_w[1]  = 128'(if5.window);
    obs_v[0]  = if3.windowValid;
    obs_v[1]  = if5.windowValid;
    obs_f[0]  = if3.frameDone;
    obs_f[1]  = if5.frameDone;
    obs_cx[0] = if3.centreX;
    obs_cx[1] = if5.centreX;
    obs_cy[0] = if3.centreY;
    obs_cy[1] = if5.centreY;
  end

  int wn [2] = '{3, 5};

  logic [PW-1:0] img [IH][IW];
  int            pos;
  logic [127:0]  ew  [2];
  logic          ev  [2];
  logic          ef  [2];
  int            ecx [2];
  int            ecy [2];

  int n_vec = 0;
  int n_err = 0;
  int cnt_v [2];
  int cnt_f [2];
  logic [127:0] fw [2];
  int fcx [2], fcy [2], dcx [2], dcy [2];

  task automatic chk(string tag, logic [127:0] o, logic [127:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    pos = 0;
    for (int k = 0; k < 2; k++) begin
      ev[k] = 1'b0; ef[k] = 1'b0; ew[k] = '0;
      ecx[k] = 0; ecy[k] = 0;
    end
  endtask

  task automatic clr_cnt();
    for (int k = 0; k < 2; k++) begin
      cnt_v[k] = 0; cnt_f[k] = 0; fw[k] = '0;
      fcx[k] = -1; fcy[k] = -1; dcx[k] = -1; dcy[k] = -1;
    end
  endtask

  task automatic check_all();
    string t;
    for (int k = 0; k < 2; k++) begin
      t = $sformatf("w%0d", wn[k]);
      chk({t, ".valid"}, 128'(obs_v[k]), 128'(ev[k]));
      chk({t, ".done"}, 128'(obs_f[k]), 128'(ef[k]));
      chk({t, ".cx"}, 128'(obs_cx[k]), 128'(ecx[k]));
      chk({t, ".cy"}, 128'(obs_cy[k]), 128'(ecy[k]));
      chk({t, ".window"}, obs_w[k], ew[k]);
      if (obs_v[k] === 1'b1) begin
        if (cnt_v[k] == 0) begin
          fw[k] = obs_w[k];
          fcx[k] = int'(obs_cx[k]);
          fcy[k] = int'(obs_cy[k]);
        end
        cnt_v[k]++;
      end
      if (obs_f[k] === 1'b1) begin
        cnt_f[k]++;
        dcx[k] = int'(obs_cx[k]);
        dcy[k] = int'(obs_cy[k]);
      end
    end
  endtask

  task automatic step(bit pv, bit s, logic [PW-1:0] pix);
    int p, x, y, w, h;
    if3.pixelValid = pv; if5.pixelValid = pv;
    if3.sof = s;         if5.sof = s;
    if3.pixelIn = pix;   if5.pixelIn = pix;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      ev[k] = 1'b0;
      ef[k] = 1'b0;
    end
    if (pv) begin
      p = s ? 0 : pos;
      x = p % IW;
      y = p / IW;
      img[y][x] = pix;
      for (int k = 0; k < 2; k++) begin
        w = wn[k];
        h = (w - 1) / 2;
        if (x >= w - 1 && y >= w - 1) begin
          ev[k] = 1'b1;
          ef[k] = (p == NPIX - 1);
          ecx[k] = x - h;
          ecy[k] = y - h;
          ew[k] = '0;
          for (int r = 0; r < w; r++)
            for (int c = 0; c < w; c++)
              ew[k][(r*w + c)*PW +: PW] = img[y-(w-1)+r][x-(w-1)+c];
        end
      end
      pos = (p + 1) % NPIX;
    end
    check_all();
  endtask

  task automatic feed(int n, bit first_sof, int maxgap);
    int g, p;
    bit s;
    for (int i = 0; i < n; i++) begin
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      for (int j = 0; j < g; j++) step(1'b0, 1'b0, PW'($urandom));
      s = first_sof && (i == 0);
      p = s ? 0 : pos;
      step(1'b1, s, PW'(((p % IW) + (p / IW)) % 16));
    end
  endtask

  task automatic frame_checks(int nf);
    chk("w3.count", 128'(cnt_v[0]), 128'(24 * nf));
    chk("w5.count", 128'(cnt_v[1]), 128'(8 * nf));
    chk("w3.ndone", 128'(cnt_f[0]), 128'(nf));
    chk("w5.ndone", 128'(cnt_f[1]), 128'(nf));
    chk("w3.done_c", 128'(dcx[0] * 256 + dcy[0]), 128'(6 * 256 + 4));
    chk("w5.done_c", 128'(dcx[1] * 256 + dcy[1]), 128'(5 * 256 + 3));
    chk("w3.first_c", 128'(fcx[0] * 256 + fcy[0]), 128'(1 * 256 + 1));
    chk("w5.first_c", 128'(fcx[1] * 256 + fcy[1]), 128'(2 * 256 + 2));
    chk("w3.first_w", fw[0], 128'(36'h4_3232_1210));
    chk("w5.first_00", 128'(fw[1][0 +: PW]), 128'(0));
    chk("w5.first_44", 128'(fw[1][24*PW +: PW]), 128'(8));
  endtask

  initial begin
    if3.pixelValid = 1'b0; if5.pixelValid = 1'b0;
    if3.sof = 1'b0;        if5.sof = 1'b0;
    if3.pixelIn = '0;      if5.pixelIn = '0;
    model_reset();
    clr_cnt();
    #12;
    check_all();
    #1 nreset = 1'b1;

    // continuous frame straight after reset release, no sof
    clr_cnt();
    feed(NPIX, 1'b0, 0);
    frame_checks(1);

    // random idle gaps
    clr_cnt();
    feed(NPIX, 1'b1, 3);
    frame_checks(1);

    // sof lands on old-frame pixel (5,3)
    feed(29, 1'b1, 0);
    clr_cnt();
    feed(NPIX, 1'b1, 0);
    frame_checks(1);

    // two frames back to back, no sof
    clr_cnt();
    feed(2 * NPIX, 1'b0, 0);
    frame_checks(2);

    // asynchronous reset between edges
    feed(20, 1'b0, 0);
    #2 nreset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    #2 nreset = 1'b1;
    clr_cnt();
    feed(NPIX, 1'b0, 0);
    frame_checks(1);

    // random valid/sof/pixel traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 49) == 0),
           PW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
